fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch stage that sits directly upstream of branch_controller. It owns the program counter, fetches words from instruction memory over a req/ack handshake and hands each instruction to the decode/branch stage over a valid/ready handshake. It supplies the return address that branch_controller pushes on CALL. After issuing a control-transfer instruction it stalls until branch_controller's resolved target (r_abs) arrives, then redirects the PC. Fetch is non-speculative.

Parameters:
PC_W, 15, program-counter and instruction-address width in words.
RESET_PC, 0, PC value loaded on reset.
BR_TIMEOUT, 16, maximum cycles spent in WAIT_BR before a fault is raised.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
imem_addr  out  PC_W  instruction-memory word address.
imem_req  out  1  fetch request; held high until imem_ack.
imem_ack  in  1  imem_data is valid this cycle.
imem_data  in  32  fetched instruction word.
instr  out  32  issued instruction register.
instr_pc  out  PC_W  address of the issued instruction.
ret_addr  out  PC_W  instr_pc+1 modulo 2^PC_W; feeds branch_controller addr.
instr_valid  out  1  instr, instr_pc and ret_addr are valid.
instr_ready  in  1  downstream accepts the instruction.
branch_taken  in  1  branch target resolved this cycle.
branch_target  in  32  r_abs from branch_controller.
stack_full  in  1  return stack is full.
stack_empty  in  1  return stack is empty.
fault  out  1  sticky error flag.
fault_code  out  2  00 none, 01 CALL on full stack, 10 RET on empty stack, 11 branch timeout.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=IDLE. Every output is 0 except imem_addr=RESET_PC.
- The opcode is instr[31:27]: JR=01101, JPC=01110, CALL=10000, RET=10001. These four opcodes are control-transfer (CT) instructions; every other opcode is sequential.
- IDLE: moves to FETCH unconditionally on the first clock after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc; the address is stable until ack.
  - On imem_ack: instr<=imem_data, instr_pc<=pc, and the state moves to ISSUE.
  - imem_ack is accepted in the same cycle as imem_req, giving a minimum fetch latency of 1 cycle.
- ISSUE:
  - instr_valid=1; instr, instr_pc and ret_addr are held stable until the handshake.
  - Fault check, made before the handshake: CALL with stack_full=1 gives fault_code 01; RET with stack_empty=1 gives fault_code 10. On a fault, instr_valid goes to 0 in that cycle and the state moves to FAULT.
  - On instr_valid&instr_ready for a sequential instruction: pc<=pc+1, wrapping 2^PC_W-1 to 0, and the state moves to FETCH.
  - On instr_valid&instr_ready for a CT instruction: the state moves to WAIT_BR and the timeout counter clears.
- WAIT_BR:
  - imem_req=0 and instr_valid=0.
  - On branch_taken: pc<=branch_target[PC_W-1:0] (upper bits are ignored) and the state moves to FETCH.
  - Otherwise the counter increments. When the counter reaches BR_TIMEOUT-1 without branch_taken, fault_code becomes 11 and the state moves to FAULT.
  - If branch_taken arrives in the same cycle as the timeout, branch_taken wins.
- FAULT: terminal state. fault=1, imem_req=0, instr_valid=0. Only rst exits it.
- branch_taken outside WAIT_BR is ignored.
- The earliest branch_taken is the cycle after the CT handshake. The next fetch of the target starts the cycle after branch_taken.
- Throughput: at most one instruction per 2 cycles (FETCH then ISSUE).
- Reset mid-operation: imem_req drops immediately; any outstanding ack is ignored after reset, because the state is IDLE.

Decomposition:
- Package fetch_pkg holds the opcode localparams (OP_JR, OP_JPC, OP_CALL, OP_RET, shared with branch_controller), the 3-bit state encoding (IDLE, FETCH, ISSUE, WAIT_BR, FAULT) and the fault_code constants.
- One natural sub-module, ct_decode: combinational. Input opcode; outputs is_ct, is_call, is_ret. It is reusable by branch_controller.

Test Plan:
- Sequential fetch: reset, then memory acks in 1 cycle with non-CT words at 0..3, ready=1 → instr_pc issued as 0,1,2,3; instr_valid high on alternate cycles; imem_addr stable while req is high.
- Backpressure and memory latency: hold instr_ready=0 for 5 cycles and delay ack by 3 cycles → instr is held constant, no pc increment, no new imem_req until the handshake.
- JPC redirect: JPC at pc=4; drive branch_taken=1 with branch_target=32'h6800_0029 two cycles after issue → next imem_addr=15'h0029; no fetch of address 5.
- CALL/RET path: CALL at pc=36 → ret_addr=37. Target 100, then RET with branch_target=37 → fetch resumes at 37.
- Stack faults: CALL with stack_full=1 → fault=1, fault_code=01, instr_valid never asserts. After reset, RET with stack_empty=1 → fault_code=10.
- Timeout, wrap and reset: with no branch_taken after a JR, fault_code=11 after 16 cycles; branch_taken on cycle 16 gives no fault. Sequential fetch from pc=32767 → next imem_addr=0. rst asserted during FETCH → imem_req=0 immediately and pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Control-transfer opcodes (instr[31:27]), also used by branch_controller.
//   - Fetch FSM state encoding.
//   - fault_code values.
package fetch_pkg;

  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JPC  = 5'b01110;
  localparam logic [4:0] OP_CALL = 5'b10000;
  localparam logic [4:0] OP_RET  = 5'b10001;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StIssue  = 3'd2,
    StWaitBr = 3'd3,
    StFault  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_CALL_FULL  = 2'b01;
  localparam logic [1:0] FAULT_RET_EMPTY  = 2'b10;
  localparam logic [1:0] FAULT_BR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ct_decode.sv
// Control-transfer opcode decoder (purely combinational).
//   opcode  : instr[31:27]
//   is_ct   : JR, JPC, CALL or RET
//   is_call : CALL
//   is_ret  : RET
module ct_decode
  import fetch_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_ct,
  output logic       is_call,
  output logic       is_ret
);

  always_comb begin
    is_call = (opcode == OP_CALL);
    is_ret  = (opcode == OP_RET);
    is_ct   = is_call || is_ret || (opcode == OP_JR) || (opcode == OP_JPC);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Non-speculative instruction-fetch stage.
// Owns the PC, fetches words over imem_req/imem_ack, issues them downstream over
// instr_valid/instr_ready and, after a control-transfer instruction, stalls until
// branch_taken delivers the resolved target.
//   clk, rst                    : clock, asynchronous active-high reset
//   imem_addr/req/ack/data      : instruction-memory fetch port
//   instr/instr_pc/ret_addr     : issued instruction, its address and address+1
//   instr_valid/instr_ready     : downstream handshake
//   branch_taken/branch_target  : resolved redirect from branch_controller
//   stack_full/stack_empty      : return-stack status for CALL/RET fault checks
//   fault/fault_code            : sticky error indication
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W       = 15,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned BR_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] ret_addr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [31:0]     branch_target,
  input  logic            stack_full,
  input  logic            stack_empty,
  output logic            fault,
  output logic [1:0]      fault_code
);

  localparam int unsigned     CntW    = (BR_TIMEOUT > 2) ? $clog2(BR_TIMEOUT) : 1;
  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);
  localparam logic [CntW-1:0] CntMax  = CntW'(BR_TIMEOUT - 1);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic [PC_W-1:0] ret_addr_q, ret_addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic is_ct, is_call, is_ret;
  logic call_fault, ret_fault;

  // Only the low PC_W bits of the target address are meaningful.
  logic unused_target_hi;
  assign unused_target_hi = ^branch_target[31:PC_W];

  ct_decode u_ct_decode (
    .opcode  (instr_q[31:27]),
    .is_ct   (is_ct),
    .is_call (is_call),
    .is_ret  (is_ret)
  );

  // Checked before the handshake so a faulting CALL/RET is never presented.
  assign call_fault = is_call && stack_full;
  assign ret_fault  = is_ret && stack_empty;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    ret_addr_d   = ret_addr_q;
    cnt_d        = cnt_q;
    fault_code_d = fault_code_q;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          ret_addr_d = pc_q + PC_W'(1);
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (call_fault) begin
          fault_code_d = FAULT_CALL_FULL;
          state_d      = StFault;
        end else if (ret_fault) begin
          fault_code_d = FAULT_RET_EMPTY;
          state_d      = StFault;
        end else begin
          instr_valid = 1'b1;
          if (instr_ready) begin
            if (is_ct) begin
              cnt_d   = '0;
              state_d = StWaitBr;
            end else begin
              pc_d    = pc_q + PC_W'(1);
              state_d = StFetch;
            end
          end
        end
      end
      StWaitBr: begin
        // A redirect arriving on the timeout cycle still wins.
        if (branch_taken) begin
          pc_d    = branch_target[PC_W-1:0];
          state_d = StFetch;
        end else if (cnt_q == CntMax) begin
          fault_code_d = FAULT_BR_TIMEOUT;
          state_d      = StFault;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= ResetPc;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      ret_addr_q   <= '0;
      cnt_q        <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      ret_addr_q   <= ret_addr_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign instr_pc   = instr_pc_q;
  assign ret_addr   = ret_addr_q;
  assign fault      = (state_q == StFault);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetch addresses and
// issued instructions into queues; monitor processes pop and compare them.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [14:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [14:0] instr_pc;
  logic [14:0] ret_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;
  logic [1:0]  fault_code;

  fetch_sequencer #(
    .PC_W       (15),
    .RESET_PC   (0),
    .BR_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .ret_addr      (ret_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          pc;
    int          ret;
  } iss_t;

  iss_t        iss_q[$];
  int          fetch_q[$];
  logic [31:0] mem[int];
  int          total = 0;
  int          bad = 0;
  int          slow_addr = -1;
  int          slow_delay = 0;

  localparam logic [4:0] TB_JR = 5'b01101, TB_JPC = 5'b01110;
  localparam logic [4:0] TB_CALL = 5'b10000, TB_RET = 5'b10001;

  function automatic logic [31:0] word_at(int a);
    if (mem.exists(a)) return mem[a];
    return {5'b00001, 12'h0, a[14:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_fetch(int a);
    fetch_q.push_back(a);
  endtask

  task automatic exp_issue(int a);
    iss_t e;
    e.data = word_at(a);
    e.pc   = a;
    e.ret  = (a + 1) % 32768;
    iss_q.push_back(e);
  endtask

  // Memory responder and fetch monitor.
  initial begin
    int          wcnt;
    int          d;
    logic        prev_req;
    logic        prev_ack;
    logic [14:0] prev_addr;
    imem_ack  = 1'b0;
    imem_data = '0;
    wcnt      = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (imem_req && prev_req && !prev_ack) check("addr_stable", 32'(imem_addr),
                                                   32'(prev_addr));
      if (imem_req) begin
        d = (int'(imem_addr) == slow_addr) ? slow_delay : 0;
        if (wcnt >= d) begin
          imem_ack  = 1'b1;
          imem_data = word_at(int'(imem_addr));
          wcnt      = 0;
          if (fetch_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_unexpected: got addr %h expected none", imem_addr);
          end else begin
            check("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
          end
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Issue monitor.
  initial begin
    logic prev_hs;
    logic hs;
    iss_t e;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) check("issue_gap", 32'(instr_valid), 32'd0);
        hs = instr_valid && instr_ready;
        if (hs) begin
          if (iss_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL issue_unexpected: got pc %h expected none", instr_pc);
          end else begin
            e = iss_q.pop_front();
            check("issue_instr", instr, e.data);
            check("issue_pc", 32'(instr_pc), 32'(e.pc));
            check("issue_ret", 32'(ret_addr), 32'(e.ret));
          end
        end
        prev_hs = hs;
      end
    end
  end

  task automatic wait_hs(int pc);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      found = instr_valid && instr_ready && (int'(instr_pc) == pc);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_hs: got no handshake expected pc %0d", pc);
    end
  endtask

  // Wait for the CT handshake at pc, then assert branch_taken in WAIT_BR cycle 'dly'.
  task automatic do_branch(int pc, int dly, logic [31:0] target);
    wait_hs(pc);
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    branch_taken  = 1'b1;
    branch_target = target;
    @(posedge clk);
    #1;
    branch_taken  = 1'b0;
    branch_target = '0;
  endtask

  task automatic wait_fault(string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check({name, "_novalid"}, 32'(instr_valid), 32'd0);
    end while (!fault && n < 30);
    total++;
    if (!fault) begin
      bad++;
      $display("FAIL %s_timeout: got fault 0 expected 1", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          n;
    rst           = 1'b1;
    instr_ready   = 1'b1;
    branch_taken  = 1'b0;
    branch_target = '0;
    stack_full    = 1'b0;
    stack_empty   = 1'b0;

    // Phase A: sequential, backpressure, JPC, CALL/RET, timeout.
    mem[4]   = {TB_JPC, 27'h0000123};
    mem[41]  = {TB_JR, 27'h0000001};
    mem[36]  = {TB_CALL, 27'h0000002};
    mem[100] = {TB_RET, 27'h0000003};
    mem[37]  = {TB_JR, 27'h0000004};
    mem[200] = {TB_JR, 27'h0000005};
    slow_addr  = 3;
    slow_delay = 3;
    foreach (fetch_q[i]) fetch_q.delete(i);
    exp_fetch(0); exp_fetch(1); exp_fetch(2); exp_fetch(3); exp_fetch(4);
    exp_fetch(41); exp_fetch(36); exp_fetch(100); exp_fetch(37); exp_fetch(200);
    exp_issue(0); exp_issue(1); exp_issue(2); exp_issue(3); exp_issue(4);
    exp_issue(41); exp_issue(36); exp_issue(100); exp_issue(37); exp_issue(200);

    @(negedge clk);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_ret_addr", 32'(ret_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    wait_hs(2);
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 20);
    held = instr;
    check("bp_first_pc", 32'(instr_pc), 32'd3);
    repeat (5) begin
      @(negedge clk);
      check("bp_instr_held", instr, held);
      check("bp_valid_held", 32'(instr_valid), 32'd1);
      check("bp_no_req", 32'(imem_req), 32'd0);
      check("bp_pc_held", 32'(imem_addr), 32'd3);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;

    do_branch(4, 2, 32'h6800_0029);
    check("jpc_addr", 32'(imem_addr), 32'h0000_0029);
    check("jpc_req", 32'(imem_req), 32'd1);
    do_branch(41, 1, 32'd36);
    do_branch(36, 1, 32'd100);
    do_branch(100, 1, 32'd37);
    do_branch(37, 16, 32'd200);
    check("late_br_nofault", 32'(fault), 32'd0);
    check("late_br_addr", 32'(imem_addr), 32'd200);

    wait_hs(200);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    check("to_pre_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    check("to_fault", 32'(fault), 32'd1);
    check("to_code", 32'(fault_code), 32'd3);
    check("to_no_req", 32'(imem_req), 32'd0);
    check("to_no_valid", 32'(instr_valid), 32'd0);
    check("a_fetch_left", 32'(fetch_q.size()), 32'd0);
    check("a_issue_left", 32'(iss_q.size()), 32'd0);

    // Phase B: wrap at 32767, then reset in the middle of a fetch.
    rst = 1'b1;
    mem[0] = {TB_JR, 27'h0000006};
    @(posedge clk);
    #1;
    check("b_rst_fault", 32'(fault), 32'd0);
    check("b_rst_code", 32'(fault_code), 32'd0);
    slow_addr  = 50;
    slow_delay = 8;
    exp_fetch(0); exp_fetch(32767); exp_fetch(0);
    exp_issue(0); exp_issue(32767); exp_issue(0);
    rst = 1'b0;
    do_branch(0, 1, 32'd32767);
    wait_hs(32767);
    @(posedge clk);
    #1;
    check("wrap_addr", 32'(imem_addr), 32'd0);
    check("wrap_req", 32'(imem_req), 32'd1);
    do_branch(0, 1, 32'd50);
    @(posedge clk);
    #1;
    check("mid_req", 32'(imem_req), 32'd1);
    check("mid_addr", 32'(imem_addr), 32'd50);
    rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(imem_req), 32'd0);
    check("rst_mid_pc", 32'(imem_addr), 32'd0);
    check("rst_mid_valid", 32'(instr_valid), 32'd0);
    check("b_fetch_left", 32'(fetch_q.size()), 32'd0);
    check("b_issue_left", 32'(iss_q.size()), 32'd0);

    // Phase C: CALL on a full stack, then RET on an empty stack.
    slow_addr  = -1;
    mem[0]     = {TB_CALL, 27'h0000007};
    stack_full = 1'b1;
    exp_fetch(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_fault("call_full");
    check("call_full_code", 32'(fault_code), 32'd1);
    repeat (3) @(negedge clk);
    check("call_full_sticky", 32'(fault), 32'd1);
    check("call_full_no_req", 32'(imem_req), 32'd0);

    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("c_rst_fault", 32'(fault), 32'd0);
    stack_full  = 1'b0;
    stack_empty = 1'b1;
    mem[0]      = {TB_RET, 27'h0000008};
    exp_fetch(0);
    rst = 1'b0;
    wait_fault("ret_empty");
    check("ret_empty_code", 32'(fault_code), 32'd2);
    check("c_fetch_left", 32'(fetch_q.size()), 32'd0);
    check("c_issue_left", 32'(iss_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
